// File: rtl/mcu_pkg.sv
// Shared timer definitions: bus width, FSM encoding and TC-register bit positions
// used by both the controller and the timer peripheral.
package mcu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STOP = 2'd1,
        RUN  = 2'd2
    } timer_state_t;

    // Bit positions of the timer strobes inside the controller's TC register
    localparam int unsigned TC_CS    = 3;
    localparam int unsigned TC_WR    = 2;
    localparam int unsigned TC_START = 1;
    localparam int unsigned TC_RD    = 0;

endpackage

// File: rtl/mcu_timer_if.sv
// Controller-to-timer strobe bundle; the controller is the master, the timer the slave.
interface mcu_timer_if #(
    parameter int unsigned DATA_W = mcu_pkg::DATA_W
) ();

    logic              timer_cs;
    logic              timer_wr;
    logic              timer_start;
    logic              timer_rd;
    logic [DATA_W-1:0] timer_datain;
    logic [DATA_W-1:0] timer_value;
    logic              timer_INT;
    logic              timer_busy;

    modport master (
        output timer_cs,
        output timer_wr,
        output timer_start,
        output timer_rd,
        output timer_datain,
        input  timer_value,
        input  timer_INT,
        input  timer_busy
    );

    modport slave (
        input  timer_cs,
        input  timer_wr,
        input  timer_start,
        input  timer_rd,
        input  timer_datain,
        output timer_value,
        output timer_INT,
        output timer_busy
    );

endinterface

// File: rtl/mcu_prescaler.sv
// Clock divider for the timer: tick is high on every PRESCALE-th enabled cycle.
module mcu_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned       CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    // A clear suppresses the tick so a reload always beats a pending count
    assign tick = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mcu_timer.sv
// Auto-reloading down-counter peripheral with a one-cycle expiry interrupt,
// controlled by the MCU controller's TC strobes.
module mcu_timer #(
    parameter int unsigned DATA_W   = mcu_pkg::DATA_W,
    parameter int unsigned PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    mcu_timer_if.slave   bus
);

    import mcu_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_STOP = STOP;
    localparam logic [1:0] ST_RUN  = RUN;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] reload;
    logic [DATA_W-1:0] value_q;
    logic              wr_q;
    logic              int_q;
    logic              busy_q;

    logic              cs_c;
    logic              wr_edge_c;
    logic              run_c;
    logic              tick_c;
    logic              expire_c;

    assign cs_c      = bus.timer_cs;
    assign wr_edge_c = cs_c & bus.timer_wr & ~wr_q;
    assign run_c     = cs_c & bus.timer_start & (state != ST_IDLE);
    assign expire_c  = tick_c & (count == DATA_W'(1));

    // Counting stops while deselected so a dropped chip select behaves as a pause
    mcu_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   ((state == ST_RUN) & cs_c),
        .clr  (wr_edge_c),
        .tick (tick_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A load decides the state outright; otherwise run toggles STOP/RUN
    always_comb begin
        state_nxt = state;
        if (wr_edge_c) begin
            if (bus.timer_datain == '0) begin
                state_nxt = ST_IDLE;
            end else if (bus.timer_start) begin
                state_nxt = ST_RUN;
            end else begin
                state_nxt = ST_STOP;
            end
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_STOP: if (run_c)  state_nxt = ST_RUN;
                ST_RUN:  if (!run_c) state_nxt = ST_STOP;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= 1'b0;
            count  <= '0;
            reload <= '0;
            int_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            wr_q   <= cs_c & bus.timer_wr;
            int_q  <= expire_c;
            busy_q <= (state_nxt == ST_RUN);
            if (wr_edge_c) begin
                reload <= bus.timer_datain;
                count  <= bus.timer_datain;
            end else if (tick_c) begin
                count <= expire_c ? reload : count - DATA_W'(1);
            end
        end
    end

    // Read snapshot lags the live count by one cycle and holds when not read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else if (cs_c & bus.timer_rd) begin
            value_q <= count;
        end
    end

    assign bus.timer_value = value_q;
    assign bus.timer_INT   = int_q;
    assign bus.timer_busy  = busy_q;

endmodule

// File: tb/tb_mcu_timer.sv
// Directed bench for mcu_timer: a per-cycle vector table on a PRESCALE=1 instance
// plus hand sequences for prescaling, pause, read lag, load priority and reset.
module tb_mcu_timer;

    import mcu_pkg::*;

    localparam logic [3:0] CS = 4'(1 << TC_CS);
    localparam logic [3:0] WR = 4'(1 << TC_WR);
    localparam logic [3:0] ST = 4'(1 << TC_START);
    localparam logic [3:0] RD = 4'(1 << TC_RD);

    typedef struct packed {
        logic [3:0]  tc;
        logic [15:0] din;
        logic [15:0] value;
        logic        intr;
        logic        busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        cs, wr, start, rd;
    logic [15:0] datain;

    int errors = 0;
    int checks = 0;

    mcu_timer_if #(.DATA_W(16)) bus1 ();
    mcu_timer_if #(.DATA_W(16)) bus4 ();

    assign bus1.timer_cs     = cs;
    assign bus1.timer_wr     = wr;
    assign bus1.timer_start  = start;
    assign bus1.timer_rd     = rd;
    assign bus1.timer_datain = datain;
    assign bus4.timer_cs     = cs;
    assign bus4.timer_wr     = wr;
    assign bus4.timer_start  = start;
    assign bus4.timer_rd     = rd;
    assign bus4.timer_datain = datain;

    mcu_timer #(.DATA_W(16), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mcu_timer #(.DATA_W(16), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] tc, input logic [15:0] din);
        cs     = tc[2'(TC_CS)];
        wr     = tc[2'(TC_WR)];
        start  = tc[2'(TC_START)];
        rd     = tc[2'(TC_RD)];
        datain = din;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{tc: CS|WR|ST|RD, din: 16'd5, value: 16'd0, intr: 1'b0, busy: 1'b1};
        vecs[1]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd5, intr: 1'b0, busy: 1'b1};
        vecs[2]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd4, intr: 1'b0, busy: 1'b1};
        vecs[3]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd3, intr: 1'b0, busy: 1'b1};
        vecs[4]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd2, intr: 1'b0, busy: 1'b1};
        vecs[5]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd1, intr: 1'b1, busy: 1'b1};
        vecs[6]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd5, intr: 1'b0, busy: 1'b1};
        vecs[7]  = '{tc: CS|RD,       din: 16'd5, value: 16'd4, intr: 1'b0, busy: 1'b0};
        vecs[8]  = '{tc: CS|RD,       din: 16'd5, value: 16'd3, intr: 1'b0, busy: 1'b0};
        vecs[9]  = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd3, intr: 1'b0, busy: 1'b1};
        vecs[10] = '{tc: CS|ST|RD,    din: 16'd5, value: 16'd3, intr: 1'b0, busy: 1'b1};
        vecs[11] = '{tc: CS|ST,       din: 16'd5, value: 16'd3, intr: 1'b0, busy: 1'b1};
        vecs[12] = '{tc: CS|WR|ST|RD, din: 16'd0, value: 16'd1, intr: 1'b0, busy: 1'b0};
        vecs[13] = '{tc: CS|WR|ST|RD, din: 16'd0, value: 16'd0, intr: 1'b0, busy: 1'b0};
        vecs[14] = '{tc: CS|ST|RD,    din: 16'd0, value: 16'd0, intr: 1'b0, busy: 1'b0};

        clk = 1'b0;
        rst = 1'b0;
        drive(4'd0, 16'd0);
        repeat (3) cyc();
        chk("reset_value", 32'(bus1.timer_value), 32'd0);
        chk("reset_int",   32'(bus1.timer_INT),   32'd0);
        chk("reset_busy",  32'(bus1.timer_busy),  32'd0);
        chk("reset_busy4", 32'(bus4.timer_busy),  32'd0);
        #2 rst = 1'b1;

        // Per-cycle table on the PRESCALE=1 instance
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].tc, vecs[i].din);
            cyc();
            chk($sformatf("vec%0d_value", i), 32'(bus1.timer_value), 32'(vecs[i].value));
            chk($sformatf("vec%0d_int", i),   32'(bus1.timer_INT),   32'(vecs[i].intr));
            chk($sformatf("vec%0d_busy", i),  32'(bus1.timer_busy),  32'(vecs[i].busy));
        end

        // PRESCALE=4, reload 3: 12-cycle period, 7-cycle pause shifts the next pulse by 7
        drive(CS|WR|ST, 16'd3);
        cyc();
        for (int k = 1; k <= 40; k++) begin
            drive((k >= 18 && k <= 24) ? CS : (CS|ST), 16'd3);
            cyc();
            chk($sformatf("pre4_int k=%0d", k),  32'(bus4.timer_INT),  32'(k == 12 || k == 31));
            chk($sformatf("pre4_busy k=%0d", k), 32'(bus4.timer_busy), 32'(!(k >= 18 && k <= 24)));
        end

        // Read tracking from 100 with one cycle of lag, then hold
        drive(CS|WR|ST, 16'd100);
        cyc();
        for (int k = 1; k <= 13; k++) begin
            drive((k <= 10) ? (CS|ST|RD) : (CS|ST), 16'd100);
            cyc();
            chk($sformatf("read_value k=%0d", k), 32'(bus1.timer_value),
                (k <= 10) ? 32'(101 - k) : 32'd91);
        end

        // Held write loads once; a reload landing on count==1 suppresses that expiry
        for (int k = 0; k <= 22; k++) begin
            if (k <= 9)       drive(CS|WR|ST, 16'd4);
            else if (k == 12) drive(CS|WR|ST, 16'd7);
            else              drive(CS|ST, 16'd7);
            cyc();
            chk($sformatf("load_int k=%0d", k), 32'(bus1.timer_INT),
                32'(k == 4 || k == 8 || k == 19));
        end

        // Asynchronous reset with count at 2, then start held high after release
        drive(CS|WR|ST|RD, 16'd5);
        cyc();
        for (int k = 1; k <= 3; k++) begin
            drive(CS|ST|RD, 16'd5);
            cyc();
        end
        chk("prerst_value", 32'(bus1.timer_value), 32'd3);
        chk("prerst_busy",  32'(bus1.timer_busy),  32'd1);
        #2 rst = 1'b0;
        #1;
        chk("asyncrst_value", 32'(bus1.timer_value), 32'd0);
        chk("asyncrst_int",   32'(bus1.timer_INT),   32'd0);
        chk("asyncrst_busy",  32'(bus1.timer_busy),  32'd0);
        chk("asyncrst_busy4", 32'(bus4.timer_busy),  32'd0);
        drive(CS|ST, 16'd5);
        repeat (2) cyc();
        #2 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("postrst_int k=%0d", k),  32'(bus1.timer_INT),  32'd0);
            chk($sformatf("postrst_busy k=%0d", k), 32'(bus1.timer_busy), 32'd0);
            chk($sformatf("postrst_int4 k=%0d", k), 32'(bus4.timer_INT),  32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcu_timer.md
Name: mcu_timer

Overview:
- Programmable 16-bit down-counting timer peripheral that sits directly downstream of the MCU controller.
- Driven by the controller's TC-register strobes (cs/wr/start/rd) and timer_datain; returns timer_value and the timer interrupt request.
- Auto-reloads on expiry and emits a single-cycle interrupt pulse. The pulse must be one cycle because the controller sets INTR[1] and stalls its FSM for every cycle timer_INT is high.

Parameters:
- DATA_W, 16: counter, reload and data-bus width.
- PRESCALE, 1: clk cycles per count tick (legal range 1..256).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- timer_cs  in  1  chip select level; when low, all other controls are ignored and the state is frozen.
- timer_wr  in  1  write level; a rising edge of (cs&wr) loads the reload value.
- timer_start  in  1  run level; the counter runs while cs&start.
- timer_rd  in  1  read level; while cs&rd, timer_value tracks the live count.
- timer_datain  in  DATA_W  reload value.
- timer_value  out  DATA_W  registered count snapshot.
- timer_INT  out  1  expiry pulse, exactly one clk wide.
- timer_busy  out  1  high in state RUN.

Behaviour:
- Reset (rst low, async): count=0, reload=0, prescaler=0, wr_q=0, timer_value=0, timer_INT=0, timer_busy=0, state=IDLE. Reset mid-count aborts immediately; no INT is produced.
- wr_q registers (cs&wr). wr_edge = cs & wr & ~wr_q. A held wr level loads only once.
- On wr_edge:
  - reload <= datain, count <= datain, prescaler <= 0.
  - Next state: IDLE if datain==0; else RUN if start is high; else STOP.
  - No tick is taken in the wr_edge cycle, even if start is high. Load has priority over count.
- run = cs & start & (state!=IDLE).
- FSM states IDLE, STOP, RUN:
  - IDLE: no valid reload. Exits only via wr_edge with datain!=0. start is ignored.
  - STOP: count and prescaler frozen. Enters RUN when run is true.
  - RUN: counts. Returns to STOP when start or cs drops; count and prescaler are preserved (pause/resume).
- Prescaler: increments each RUN cycle. tick = RUN & (prescaler==PRESCALE-1), after which the prescaler returns to 0. With PRESCALE=1, tick fires every RUN cycle.
- On tick:
  - If count==1: count <= reload and timer_INT <= 1 on the next edge. Otherwise count <= count-1.
  - Expiry period = reload*PRESCALE clk cycles.
- timer_INT is registered. It is high for exactly one cycle per expiry, never level-held. Back-to-back expiries (reload=1, PRESCALE=1) produce a pulse every cycle; this is legal.
- Read: timer_value <= count on each edge while cs&rd (1-cycle latency); otherwise it holds its last value. A read never disturbs counting.
- Simultaneous wr_edge and tick: the load wins, the tick is discarded, and no INT fires.
- Width rule: all arithmetic is unsigned DATA_W. count never wraps below 0 because reload happens at 1.
- cs low during RUN: treated as start low (pause). On cs reassertion, wr_edge detection restarts from the registered wr_q.

Decomposition:
- Package mcu_pkg:
  - DATA_W constant.
  - timer_state_t enum {IDLE, STOP, RUN}.
  - TC bit-index constants TC_CS=3, TC_WR=2, TC_START=1, TC_RD=0, shared with the controller.
- One sub-module, mcu_prescaler: parameter PRESCALE; inputs clk, rst, en, clr; output tick. The parent holds the FSM, count, reload and read logic.

Test Plan:
- PRESCALE=1, datain=5, pulse cs&wr, then hold cs&start → timer_INT pulses exactly 1 cycle wide, every 5 cycles; timer_busy=1.
- PRESCALE=4, datain=3, run → INT every 12 cycles. Drop start for 7 cycles mid-count, then reassert → next INT delayed by exactly 7 cycles.
- Run with datain=100, hold cs&rd → timer_value decrements 100, 99, …, lagging the count by 1 cycle. Release rd → timer_value holds.
- Hold wr high with start high for 10 cycles → exactly one load. Drive a new datain=7 edge on the cycle the count would hit 1 → no INT; next INT 7 cycles later.
- Load datain=0 and start → state stays IDLE, no INT, timer_busy=0.
- Assert rst low mid-run at count=2 → all outputs 0 asynchronously. After release with start still high → remains IDLE, no INT.
